fb_addr_gen: RTL and testbench
==============================

FB_ADDR_GEN -- requirements
Module: fb_addr_gen

Interface
REQ-001 SHALL have parameter HSIZE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter VSIZE, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter AW, default 19, meaning address width; AW >= clog2(HSIZE*VSIZE).
REQ-004 SHALL have port CLK  input  1  pixel clock; all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Vsync  input  1  vertical sync, active-low.
REQ-007 SHALL have port Hsync  input  1  horizontal sync, active-low.
REQ-008 SHALL have port DE  input  1  data enable, high during active pixels.
REQ-009 SHALL have port mode  input  2  bit0 = vertical flip, bit1 = horizontal mirror.
REQ-010 SHALL have port addr  output  AW  frame-buffer read address.
REQ-011 SHALL have port addr_valid  output  1  addr is a valid pixel address this cycle.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse on Vsync falling edge.
REQ-013 SHALL have port err  output  1  sticky per frame: line or pixel overrun detected.

Function
REQ-014 SHALL implement FSM states WAIT_VS, VBLANK, LINE, HBLANK, DONE.
REQ-015 WAIT_VS -> VBLANK on Vsync falling edge (Vsync 1->0 between consecutive samples); from any state, that edge returns FSM to VBLANK.
REQ-016 On Vsync falling edge: latch mode into mode_q, set row = 0, clear err, pulse frame_start next cycle.
REQ-017 mode changes mid-frame SHALL be ignored until next Vsync falling edge.
REQ-018 VBLANK/HBLANK -> LINE on DE rising edge; LINE -> HBLANK on DE falling edge, row increments by 1.
REQ-019 HBLANK -> DONE when row reaches VSIZE; DONE ignores DE until next Vsync falling edge.
REQ-020 DE rising edge while in DONE SHALL set err; addr_valid stays 0.
REQ-021 Column counter x SHALL reset to 0 at each DE rising edge and increment per DE-high cycle, saturating at HSIZE-1.
REQ-022 DE high for more than HSIZE cycles SHALL set err; extra cycles addr_valid = 0, addr holds last value.
REQ-023 row_base SHALL be maintained incrementally (no multiplier): +HSIZE per line normally, start (VSIZE-1)*HSIZE and -HSIZE per line when mode_q[0]=1.
REQ-024 Column term SHALL be x normally, HSIZE-1-x when mode_q[1]=1.
REQ-025 addr SHALL equal row_base + column term, registered; latency exactly 1 cycle from the DE-high sample to addr/addr_valid.
REQ-026 Hsync low SHALL force x = 0 and abort LINE to HBLANK without incrementing row if DE still high (sets err).
REQ-027 All arithmetic SHALL be unsigned AW bits; no wrap below 0 or above HSIZE*VSIZE-1 under legal input.
REQ-028 Simultaneous Vsync falling edge and DE rising edge: Vsync handling wins, pixel not counted.

Reset
REQ-029 RESET SHALL asynchronously force state WAIT_VS, addr = 0, addr_valid = 0, frame_start = 0, err = 0, row = 0, x = 0, mode_q = 0.
REQ-030 Reset deassertion mid-frame SHALL produce no addr_valid until after the next Vsync falling edge.

Structure
REQ-031 FSM state encoding and mode bit indices SHALL live in shared package fb_pkg.
REQ-032 Edge detection of Vsync/DE SHALL be a sub-module edge_det (registered prev sample, rise/fall outputs).

Verification (HSIZE=8, VSIZE=4, AW=5)
REQ-033 mode=00, 4 lines of 8 DE cycles -> addr 0..31 in order, 1-cycle latency, err=0.
REQ-034 mode=01 -> line 0 addr 24..31, line 3 addr 0..7.
REQ-035 mode=10 -> line 0 addr 7..0; mode=11 -> line 0 addr 31..24.
REQ-036 DE high 10 cycles on line 0 -> addr 0..7 valid, 2 cycles invalid, err=1; cleared at next frame_start.
REQ-037 5th DE line after 4 -> no addr_valid, err=1; mode toggled mid-frame -> no effect on current frame.
REQ-038 RESET pulsed mid-line 2 -> outputs 0 immediately; addr_valid stays 0 until next Vsync falling edge.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer address generator: FSM encoding,
// mode bit positions and a width helper.
package fb_pkg;

  typedef enum logic [2:0] {
    WAIT_VS = 3'd0,
    VBLANK  = 3'd1,
    LINE    = 3'd2,
    HBLANK  = 3'd3,
    DONE    = 3'd4
  } fb_state_e;

  localparam int MODE_VFLIP   = 0;
  localparam int MODE_HMIRROR = 1;

  // Minimum counter width able to hold values 0..n-1, never below 1 bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Single-signal edge detector: registered previous sample with combinational
// rise/fall outputs for the current cycle.
module edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) prev <= RST_VAL;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/fb_addr_gen.sv
// Frame-buffer read address generator driven by video timing, with optional
// vertical flip and horizontal mirror latched once per frame.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int HSIZE = 640,
  parameter int VSIZE = 480,
  parameter int AW    = 19
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          Vsync,
  input  logic          Hsync,
  input  logic          DE,
  input  logic [1:0]    mode,
  output logic [AW-1:0] addr,
  output logic          addr_valid,
  output logic          frame_start,
  output logic          err
);

  localparam int XW = width_of(HSIZE);
  localparam int RW = width_of(VSIZE + 1);

  localparam logic [AW-1:0] H_STEP    = AW'(HSIZE);
  localparam logic [AW-1:0] H_LAST    = AW'(HSIZE - 1);
  localparam logic [AW-1:0] FLIP_BASE = AW'((VSIZE - 1) * HSIZE);
  localparam logic [XW-1:0] X_LAST    = XW'(HSIZE - 1);
  localparam logic [RW-1:0] ROW_END   = RW'(VSIZE);

  fb_state_e     state, state_n;
  logic [1:0]    mode_q;
  logic [RW-1:0] row;
  logic [AW-1:0] row_base;
  logic [XW-1:0] x;

  logic vs_fall, unused_vs_rise, de_rise, de_fall;
  logic emit, first_px, line_end, err_set;
  logic [AW-1:0] col, col_term;

  // Vsync history starts low so a reset released during the sync pulse
  // cannot fake a frame start.
  edge_det #(.RST_VAL(1'b0)) u_vs_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .sig   (Vsync),
    .rise  (unused_vs_rise),
    .fall  (vs_fall)
  );

  edge_det #(.RST_VAL(1'b0)) u_de_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .sig   (DE),
    .rise  (de_rise),
    .fall  (de_fall)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= WAIT_VS;
    else       state <= state_n;
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    emit     = 1'b0;
    first_px = 1'b0;
    line_end = 1'b0;
    err_set  = 1'b0;
    if (vs_fall) begin
      state_n = VBLANK;
    end else begin
      case (state)
        WAIT_VS: ;
        VBLANK: begin
          if (de_rise) begin
            state_n  = LINE;
            emit     = 1'b1;
            first_px = 1'b1;
          end
        end
        HBLANK: begin
          if (row == ROW_END) begin
            state_n = DONE;
            err_set = de_rise;
          end else if (de_rise) begin
            state_n  = LINE;
            emit     = 1'b1;
            first_px = 1'b1;
          end
        end
        LINE: begin
          if (de_fall) begin
            state_n  = HBLANK;
            line_end = 1'b1;
          end else if (!Hsync) begin
            state_n = HBLANK;
            err_set = 1'b1;
          end else if (x == X_LAST) begin
            err_set = 1'b1;
          end else begin
            emit = 1'b1;
          end
        end
        DONE:    err_set = de_rise;
        default: state_n = WAIT_VS;
      endcase
    end
  end

  // x holds the column of the last emitted pixel, so the next one is x+1.
  assign col      = first_px ? '0 : AW'(x) + AW'(1);
  assign col_term = mode_q[MODE_HMIRROR] ? (H_LAST - col) : col;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr        <= '0;
      addr_valid  <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      row         <= '0;
      row_base    <= '0;
      x           <= '0;
      mode_q      <= 2'b00;
    end else begin
      frame_start <= vs_fall;
      addr_valid  <= emit;
      if (emit) addr <= row_base + col_term;

      if (vs_fall) begin
        mode_q   <= mode;
        row      <= '0;
        err      <= 1'b0;
        x        <= '0;
        row_base <= mode[MODE_VFLIP] ? FLIP_BASE : '0;
      end else begin
        if (emit)        x <= col[XW-1:0];
        else if (!Hsync) x <= '0;

        if (err_set) err <= 1'b1;

        // Base stops at the last line so it never steps outside the frame.
        if (line_end) begin
          row <= row + RW'(1);
          if (row + RW'(1) < ROW_END)
            row_base <= mode_q[MODE_VFLIP] ? (row_base - H_STEP) : (row_base + H_STEP);
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_addr_gen.sv
// Directed scoreboard bench for fb_addr_gen at HSIZE=8, VSIZE=4, AW=5.
module tb_fb_addr_gen;

  localparam int HS = 8;
  localparam int VS = 4;
  localparam int AW = 5;

  logic          CLK, RESET, Vsync, Hsync, DE;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic          addr_valid, frame_start, err;

  int vectors     = 0;
  int miscompares = 0;
  string cur_tag  = "init";
  logic [AW-1:0] last_a = '0;
  logic [AW+1:0] sb[$];

  fb_addr_gen #(.HSIZE(HS), .VSIZE(VS), .AW(AW)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .Vsync       (Vsync),
    .Hsync       (Hsync),
    .DE          (DE),
    .mode        (mode),
    .addr        (addr),
    .addr_valid  (addr_valid),
    .frame_start (frame_start),
    .err         (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [AW-1:0] exp_addr(input int r, input int c, input logic [1:0] m);
    int rr, cc;
    rr = m[0] ? (VS - 1 - r) : r;
    cc = m[1] ? (HS - 1 - c) : c;
    return AW'(rr * HS + cc);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, queue expectation, compare just after posedge.
  task automatic step(input logic vs, input logic hs, input logic de,
                      input logic ev, input logic [AW-1:0] ea, input logic efs);
    logic [AW+1:0] e;
    @(negedge CLK);
    Vsync = vs;
    Hsync = hs;
    DE    = de;
    if (ev) last_a = ea;
    sb.push_back({ev, last_a, efs});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check(cur_tag, 8'({addr_valid, addr, frame_start}), 8'(e));
  endtask

  task automatic vsync_pulse();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic line(input int r, input int n, input logic [1:0] m, input bit active);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b1, 1'b1, active && (i < HS), exp_addr(r, i, m), 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    RESET = 1'b1;
    Vsync = 1'b1;
    Hsync = 1'b1;
    DE    = 1'b0;
    mode  = 2'b00;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("rst_addr",  8'(addr),        8'h00);
    check("rst_valid", 8'(addr_valid),  8'h00);
    check("rst_fs",    8'(frame_start), 8'h00);
    check("rst_err",   8'(err),         8'h00);
    @(negedge CLK);
    RESET = 1'b0;

    cur_tag = "idle";
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    line(0, HS, 2'b00, 1'b0);

    cur_tag = "mode00";
    vsync_pulse();
    for (int r = 0; r < VS; r++) line(r, HS, 2'b00, 1'b1);
    check("mode00_err", 8'(err), 8'h00);
    cur_tag = "extra_line";
    line(0, HS, 2'b00, 1'b0);
    check("extra_line_err", 8'(err), 8'h01);

    cur_tag = "mode01";
    mode = 2'b01;
    vsync_pulse();
    mode = 2'b10;
    for (int r = 0; r < VS; r++) line(r, HS, 2'b01, 1'b1);
    check("mode01_err", 8'(err), 8'h00);

    cur_tag = "mode10";
    vsync_pulse();
    line(0, HS, 2'b10, 1'b1);
    cur_tag = "mode11";
    mode = 2'b11;
    vsync_pulse();
    line(0, HS, 2'b11, 1'b1);

    cur_tag = "overrun";
    mode = 2'b00;
    vsync_pulse();
    line(0, HS + 2, 2'b00, 1'b1);
    check("overrun_err", 8'(err), 8'h01);
    vsync_pulse();
    check("overrun_err_clear", 8'(err), 8'h00);

    cur_tag = "hsync_abort";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, exp_addr(0, i, 2'b00), 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("hsync_abort_err", 8'(err), 8'h01);
    line(0, HS, 2'b00, 1'b1);

    cur_tag = "vs_de_same_cycle";
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("vs_de_err", 8'(err), 8'h00);
    line(0, HS, 2'b00, 1'b1);

    cur_tag = "reset_mid_line";
    vsync_pulse();
    line(0, HS, 2'b00, 1'b1);
    line(1, HS, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, exp_addr(2, i, 2'b00), 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    check("midrst_addr",  8'(addr),        8'h00);
    check("midrst_valid", 8'(addr_valid),  8'h00);
    check("midrst_fs",    8'(frame_start), 8'h00);
    check("midrst_err",   8'(err),         8'h00);
    last_a = '0;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    line(3, HS, 2'b00, 1'b0);
    cur_tag = "after_reset_frame";
    vsync_pulse();
    line(0, HS, 2'b00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
